tile_skew_feeder: RTL and testbench

Transmit-side front end for the systolic tile input ports. It accepts one unskewed feature-map vector and one weight vector per handshake beat for a burst of K_LEN beats. It drives them onto the tile's fmap/weight buses with the diagonal skew the array needs, where lane k is delayed k cycles. It pulses the tile enable, zero-flushes the skew pipeline after the last beat, and signals completion.

---
 rtl/tile_skew_feeder.sv | 161 ++++++++++++++++
 tb/tb_tile_skew_feeder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tile_skew_feeder
// Brief    : Accepts K_LEN unskewed fmap/weight beats and drives them onto the
//            systolic tile with lane k delayed k cycles, then zero-flushes.
// Revision : 1.0 - initial release
// ============================================================================
module tile_skew_feeder #(
    parameter int D_BW  = 8,
    parameter int ROWS  = 5,
    parameter int COLS  = 5,
    parameter int K_LEN = 25
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [D_BW*ROWS-1:0] i_fmap_vec,
    input  logic [D_BW*COLS-1:0] i_weight_vec,
    output logic [D_BW*ROWS-1:0] o_fmap,
    output logic [D_BW*COLS-1:0] o_weight,
    output logic                 o_en_tf,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_underrun
);

    localparam int c_MAXD  = ((ROWS > COLS) ? ROWS : COLS) - 1;
    localparam int c_CNT_W = $clog2(K_LEN + 1);
    localparam int c_DRN_W = (c_MAXD > 1) ? $clog2(c_MAXD) : 1;

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(K_LEN - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_DRN_W-1:0] c_DRN_LAST = c_DRN_W'((c_MAXD > 0) ? (c_MAXD - 1) : 0);
    localparam logic [c_DRN_W-1:0] c_DRN_ONE  = c_DRN_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic [c_DRN_W-1:0]   r_drn;
    logic [c_DRN_W-1:0]   w_drn_nxt;
    logic                 r_underrun;
    logic                 w_underrun_nxt;
    logic                 r_en_tf;
    logic                 w_en_tf_nxt;
    logic                 w_hs;

    assign w_hs = i_valid & (r_state == S_FEED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_drn      <= '0;
            r_underrun <= 1'b0;
            r_en_tf    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_drn      <= w_drn_nxt;
            r_underrun <= w_underrun_nxt;
            r_en_tf    <= w_en_tf_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_drn_nxt      = r_drn;
        w_underrun_nxt = r_underrun;
        w_en_tf_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt    = S_FEED;
                    w_cnt_nxt      = '0;
                    w_underrun_nxt = 1'b0;
                end
            end
            S_FEED: begin
                if (w_hs) begin
                    // Lane 0 shows beat 0 one cycle after its handshake.
                    w_en_tf_nxt = (r_cnt == '0);
                    w_cnt_nxt   = r_cnt + c_CNT_ONE;
                    if (r_cnt == c_CNT_LAST) begin
                        w_drn_nxt   = '0;
                        w_state_nxt = (c_MAXD == 0) ? S_DONE : S_DRAIN;
                    end
                end else begin
                    w_underrun_nxt = 1'b1;
                end
            end
            S_DRAIN: begin
                w_drn_nxt = r_drn + c_DRN_ONE;
                if (r_drn == c_DRN_LAST) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign o_ready    = (r_state == S_FEED);
    assign o_busy     = (r_state != S_IDLE);
    assign o_done     = (r_state == S_DONE);
    assign o_underrun = r_underrun;
    assign o_en_tf    = r_en_tf;

    // Lane k is a k+1 deep shift chain; non-handshake cycles inject zeros.
    generate
        for (genvar r = 0; r < ROWS; r++) begin : g_fmap_lane
            logic [D_BW-1:0] r_pipe [0:r];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i <= r; i++) begin
                        r_pipe[i] <= '0;
                    end
                end else begin
                    r_pipe[0] <= w_hs ? i_fmap_vec[r*D_BW +: D_BW] : '0;
                    for (int i = 1; i <= r; i++) begin
                        r_pipe[i] <= r_pipe[i-1];
                    end
                end
            end
            assign o_fmap[r*D_BW +: D_BW] = r_pipe[r];
        end

        for (genvar c = 0; c < COLS; c++) begin : g_weight_lane
            logic [D_BW-1:0] r_pipe [0:c];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i <= c; i++) begin
                        r_pipe[i] <= '0;
                    end
                end else begin
                    r_pipe[0] <= w_hs ? i_weight_vec[c*D_BW +: D_BW] : '0;
                    for (int i = 1; i <= c; i++) begin
                        r_pipe[i] <= r_pipe[i-1];
                    end
                end
            end
            assign o_weight[c*D_BW +: D_BW] = r_pipe[c];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_tile_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_tile_skew_feeder
// Brief    : Directed self-checking bench for tile_skew_feeder (5x5 K=4 and
//            3x6 K=1 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tile_skew_feeder;

    localparam int MAXD_A = 4;

    logic        clk;
    logic        rst;

    logic        a_start, a_valid, a_ready, a_en_tf, a_busy, a_done, a_unr;
    logic [39:0] a_fmap_in, a_wt_in, a_fmap, a_wt;

    logic        b_start, b_valid, b_ready, b_en_tf, b_busy, b_done, b_unr;
    logic [23:0] b_fmap_in, b_fmap;
    logic [47:0] b_wt_in, b_wt;

    int n_total;
    int n_bad;

    tile_skew_feeder #(.D_BW(8), .ROWS(5), .COLS(5), .K_LEN(4)) dut_a (
        .clk          (clk),
        .rst          (rst),
        .i_start      (a_start),
        .i_valid      (a_valid),
        .o_ready      (a_ready),
        .i_fmap_vec   (a_fmap_in),
        .i_weight_vec (a_wt_in),
        .o_fmap       (a_fmap),
        .o_weight     (a_wt),
        .o_en_tf      (a_en_tf),
        .o_busy       (a_busy),
        .o_done       (a_done),
        .o_underrun   (a_unr)
    );

    tile_skew_feeder #(.D_BW(8), .ROWS(3), .COLS(6), .K_LEN(1)) dut_b (
        .clk          (clk),
        .rst          (rst),
        .i_start      (b_start),
        .i_valid      (b_valid),
        .o_ready      (b_ready),
        .i_fmap_vec   (b_fmap_in),
        .i_weight_vec (b_wt_in),
        .o_fmap       (b_fmap),
        .o_weight     (b_wt),
        .o_en_tf      (b_en_tf),
        .o_busy       (b_busy),
        .o_done       (b_done),
        .o_underrun   (b_unr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [39:0] fvec(input int b);
        logic [39:0] v;
        for (int r = 0; r < 5; r++) v[r*8 +: 8] = 8'(16 * b + r);
        return v;
    endfunction

    function automatic logic [39:0] wvec(input int b);
        logic [39:0] v;
        for (int c = 0; c < 5; c++) v[c*8 +: 8] = 8'(128 + b);
        return v;
    endfunction

    // Idle cycles with junk offered on i_valid: nothing may be accepted.
    task automatic idle_a(input int n, input logic exp_unr);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("idle%0d_busy", i), 64'(a_busy), 64'(0));
            chk($sformatf("idle%0d_ready", i), 64'(a_ready), 64'(0));
            chk($sformatf("idle%0d_fmap", i), 64'(a_fmap), 64'(0));
            chk($sformatf("idle%0d_wt", i), 64'(a_wt), 64'(0));
            chk($sformatf("idle%0d_unr", i), 64'(a_unr), 64'(exp_unr));
            a_start = 1'b0;
            a_valid = 1'b1;
            a_fmap_in = {5{8'hEE}};
            a_wt_in   = {5{8'hEE}};
            step();
        end
    endtask

    // One 4-beat burst on dut_a starting with i_start in relative cycle 0.
    // Optional bubble of bub_len cycles after beat bub_after; optional i_start
    // poke in cycle 2. Ends after the o_done cycle.
    task automatic run_burst_a(input string nm, input int bub_after, input int bub_len,
                               input bit poke_start, input logic prev_unr);
        int  beat_at [0:31];
        bit  vld     [0:31];
        int  k, k_last, k_done, bub_k0, j;
        logic [39:0] ef, ew;
        for (int i = 0; i < 32; i++) begin
            beat_at[i] = -1;
            vld[i]     = 1'b1;
        end
        k = 1;
        bub_k0 = -1;
        for (int b = 0; b < 4; b++) begin
            if (bub_len > 0 && b == bub_after + 1) begin
                bub_k0 = k;
                for (int i = 0; i < bub_len; i++) begin
                    vld[k] = 1'b0;
                    k++;
                end
            end
            beat_at[k] = b;
            k++;
        end
        k_last = k - 1;
        k_done = k_last + 1 + MAXD_A;
        for (int kk = 0; kk <= k_done; kk++) begin
            ef = '0;
            ew = '0;
            for (int r = 0; r < 5; r++) begin
                j = kk - 1 - r;
                if (j >= 0 && beat_at[j] >= 0) begin
                    ef[r*8 +: 8] = 8'(16 * beat_at[j] + r);
                    ew[r*8 +: 8] = 8'(128 + beat_at[j]);
                end
            end
            chk($sformatf("%s_fmap_k%0d", nm, kk), 64'(a_fmap), 64'(ef));
            chk($sformatf("%s_wt_k%0d", nm, kk), 64'(a_wt), 64'(ew));
            chk($sformatf("%s_ready_k%0d", nm, kk), 64'(a_ready), 64'(kk >= 1 && kk <= k_last));
            chk($sformatf("%s_busy_k%0d", nm, kk), 64'(a_busy), 64'(kk >= 1));
            chk($sformatf("%s_done_k%0d", nm, kk), 64'(a_done), 64'(kk == k_done));
            chk($sformatf("%s_en_k%0d", nm, kk), 64'(a_en_tf), 64'(kk == 2));
            chk($sformatf("%s_unr_k%0d", nm, kk), 64'(a_unr),
                64'((kk == 0) ? prev_unr : (bub_k0 >= 0 && kk > bub_k0)));
            a_start = (kk == 0) || (poke_start && kk == 2);
            a_valid = vld[kk];
            if (beat_at[kk] >= 0) begin
                a_fmap_in = fvec(beat_at[kk]);
                a_wt_in   = wvec(beat_at[kk]);
            end else begin
                a_fmap_in = {5{8'hEE}};
                a_wt_in   = {5{8'hEE}};
            end
            step();
        end
        a_start = 1'b0;
    endtask

    initial begin
        logic [23:0] ebf;
        logic [47:0] ebw;
        n_total = 0;
        n_bad   = 0;
        rst = 1'b1;
        a_start = 1'b0; a_valid = 1'b0; a_fmap_in = '0; a_wt_in = '0;
        b_start = 1'b0; b_valid = 1'b0; b_fmap_in = '0; b_wt_in = '0;
        step();
        step();
        chk("rst_fmap", 64'(a_fmap), 64'(0));
        chk("rst_wt", 64'(a_wt), 64'(0));
        chk("rst_ready", 64'(a_ready), 64'(0));
        chk("rst_busy", 64'(a_busy), 64'(0));
        chk("rst_done", 64'(a_done), 64'(0));
        chk("rst_en", 64'(a_en_tf), 64'(0));
        chk("rst_unr", 64'(a_unr), 64'(0));
        rst = 1'b0;
        idle_a(2, 1'b0);

        // Underrun burst, then back-to-back basic burst with i_start poked mid-FEED.
        run_burst_a("unr", 1, 2, 1'b0, 1'b0);
        run_burst_a("b2b", -5, 0, 1'b1, 1'b1);
        idle_a(3, 1'b0);

        // Asynchronous reset in the middle of FEED.
        a_start = 1'b1; a_valid = 1'b1; a_fmap_in = {5{8'hEE}}; a_wt_in = {5{8'hEE}};
        step();
        a_start = 1'b0; a_valid = 1'b0;
        step();
        a_valid = 1'b1; a_fmap_in = fvec(0); a_wt_in = wvec(0);
        step();
        a_fmap_in = fvec(1); a_wt_in = wvec(1);
        chk("pre_rst_en", 64'(a_en_tf), 64'(1));
        chk("pre_rst_wt", 64'(a_wt), 64'(wvec(0) & 40'h00000000FF));
        chk("pre_rst_unr", 64'(a_unr), 64'(1));
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_fmap", 64'(a_fmap), 64'(0));
        chk("mid_rst_wt", 64'(a_wt), 64'(0));
        chk("mid_rst_ready", 64'(a_ready), 64'(0));
        chk("mid_rst_busy", 64'(a_busy), 64'(0));
        chk("mid_rst_en", 64'(a_en_tf), 64'(0));
        chk("mid_rst_unr", 64'(a_unr), 64'(0));
        step();
        rst = 1'b0;
        idle_a(4, 1'b0);
        run_burst_a("fresh", -5, 0, 1'b0, 1'b0);
        idle_a(2, 1'b0);

        // Asymmetric 3x6 array, single beat, MAXD=5.
        for (int k = 0; k < 10; k++) begin
            ebf = '0;
            ebw = '0;
            for (int r = 0; r < 3; r++) if (k == 2 + r) ebf[r*8 +: 8] = 8'(8'hA0 + r);
            for (int c = 0; c < 6; c++) if (k == 2 + c) ebw[c*8 +: 8] = 8'(8'hB0 + c);
            chk($sformatf("asym_fmap_k%0d", k), 64'(b_fmap), 64'(ebf));
            chk($sformatf("asym_wt_k%0d", k), 64'(b_wt), 64'(ebw));
            chk($sformatf("asym_done_k%0d", k), 64'(b_done), 64'(k == 7));
            chk($sformatf("asym_busy_k%0d", k), 64'(b_busy), 64'(k >= 1 && k <= 7));
            chk($sformatf("asym_ready_k%0d", k), 64'(b_ready), 64'(k == 1));
            chk($sformatf("asym_en_k%0d", k), 64'(b_en_tf), 64'(k == 2));
            b_start = (k == 0);
            b_valid = 1'b1;
            if (k == 1) begin
                b_fmap_in = 24'hA2A1A0;
                b_wt_in   = 48'hB5B4B3B2B1B0;
            end else begin
                b_fmap_in = {3{8'hEE}};
                b_wt_in   = {6{8'hEE}};
            end
            step();
        end
        chk("asym_unr", 64'(b_unr), 64'(0));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
`default_nettype wire
